// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared state type and bit-scan helpers for prio_enc_scan.
package prio_enc_pkg;

   typedef enum logic {IDLE, SCAN} state_t;

   function automatic int lsb(input logic [63:0] v);
      lsb = 0;
      for (int i = 63; i >= 0; i--)
         if (v[i]) lsb = i;
   endfunction

   function automatic int popcount(input logic [63:0] v);
      popcount = 0;
      for (int i = 0; i < 64; i++)
         if (v[i]) popcount++;
   endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// prio_enc_lsb: lowest-set-bit index, nonzero and one-hot detection of a vector.
module prio_enc_lsb
   import prio_enc_pkg::*;
#(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] v,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         onehot
);

   always_comb begin
      idx    = W'(lsb(64'(v)));
      any    = |v;
      onehot = popcount(64'(v)) == 1;
   end

endmodule

// File: rtl/prio_enc_scan.sv
// prio_enc_scan: captures a request vector and streams its set-bit indices, lowest first.
// Optional macro PRIO_ENC_SCAN_CNT_EN adds out_cnt (remaining bits including the current one).
module prio_enc_scan
   import prio_enc_pkg::*;
#(
   parameter int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         out_last,
   output logic         zero_in
`ifdef PRIO_ENC_SCAN_CNT_EN
   ,
   output logic [W:0]   out_cnt
`endif
);

   state_t       state, state_nx;
   logic [N-1:0] pending, pending_nx;
   logic         zero_nx, pend_any;

   prio_enc_lsb #(.N(N)) u_lsb (
      .v      (pending),
      .idx    (out_idx),
      .any    (pend_any),
      .onehot (out_last)
   );

   assign in_ready  = state == IDLE;
   assign out_valid = state == SCAN && pend_any;

`ifdef PRIO_ENC_SCAN_CNT_EN
   assign out_cnt = out_valid ? (W+1)'(popcount(64'(pending))) : '0;
`endif

   always_comb begin
      state_nx   = state;
      pending_nx = pending;
      zero_nx    = 1'b0;
      if (state == IDLE) begin
         zero_nx = in_valid && !(|in_data);
         if (in_valid && |in_data) begin
            state_nx   = SCAN;
            pending_nx = in_data;
         end
      end else if (out_ready) begin
         // clearing the lowest set bit retires exactly the index being reported
         pending_nx = pending & (pending - N'(1));
         state_nx   = out_last ? IDLE : SCAN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         zero_in <= 1'b0;
      end else begin
         state   <= state_nx;
         pending <= pending_nx;
         zero_in <= zero_nx;
      end
   end

endmodule

// File: tb/tb_prio_enc_scan.sv
// tb_prio_enc_scan: scoreboard bench for prio_enc_scan with directed and random vectors.
module tb_prio_enc_scan;

   localparam int N = 8;
   localparam int W = $clog2(N);

   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         in_ready, out_valid, out_last, zero_in;
   logic [W-1:0] out_idx;
`ifdef PRIO_ENC_SCAN_CNT_EN
   logic [W:0]   out_cnt;
`endif

   typedef struct {int idx; bit last; int t;} beat_t;
   beat_t q[$];
   int    zq[$];
   int    cyc = 0, total = 0, bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   prio_enc_scan #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .zero_in   (zero_in)
`ifdef PRIO_ENC_SCAN_CNT_EN
      ,
      .out_cnt   (out_cnt)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int remain();
      int c = 0;
      for (int i = 0; i < q.size(); i++) begin
         c++;
         if (q[i].last) break;
      end
      return c;
   endfunction

   // the model is idle exactly when no expected beat is outstanding
   task automatic step(input logic v, input logic [N-1:0] d, input logic r, input logic rs);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      rst       = rs;
      chk("in_ready", int'(in_ready), int'(q.size() == 0));
      if (rs) begin
         q.delete();
         zq.delete();
      end else if (v && q.size() == 0) begin
         if (d == '0) zq.push_back(cyc + 1);
         else begin
            int hi = 0;
            for (int i = 0; i < N; i++) if (d[i]) hi = i;
            for (int i = 0; i < N; i++) if (d[i]) q.push_back('{i, i == hi, cyc + 1});
         end
      end
   endtask

   always @(negedge clk) begin
      bit ev, ez;
      if (!rst) begin
         ev = q.size() > 0 && q[0].t <= cyc;
         ez = zq.size() > 0 && zq[0] == cyc;
         chk("out_valid", int'(out_valid), int'(ev));
         chk("zero_in", int'(zero_in), int'(ez));
         if (ez) void'(zq.pop_front());
         if (ev && out_valid) begin
            chk("out_idx", int'(out_idx), q[0].idx);
            chk("out_last", int'(out_last), int'(q[0].last));
`ifdef PRIO_ENC_SCAN_CNT_EN
            chk("out_cnt", int'(out_cnt), remain());
`endif
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      logic [N-1:0] d;
      int sel;
      repeat (3) @(posedge clk);
      step(0, '0, 0, 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_zero_in", int'(zero_in), 0);
      // single bit
      step(1, 8'b0000_0001, 1, 0);
      repeat (3) step(0, '0, 1, 0);
      // two bits
      step(1, 8'b1000_0100, 1, 0);
      repeat (4) step(0, '0, 1, 0);
      // zero vector
      step(1, 8'h00, 1, 0);
      repeat (3) step(0, '0, 1, 0);
      // backpressure with offers during the scan
      step(1, 8'b0010_0010, 0, 0);
      repeat (3) step(1, 8'hFF, 0, 0);
      repeat (3) step(0, '0, 1, 0);
      // reset mid-scan, with a simultaneous offer
      step(1, 8'hFF, 1, 0);
      step(0, '0, 1, 0);
      step(0, '0, 1, 0);
      step(1, 8'h08, 1, 1);
      step(0, '0, 1, 0);
      chk("post_rst_out_valid", int'(out_valid), 0);
      repeat (10) step(0, '0, 1, 0);
      // random traffic
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom % 4);
         d = sel == 0 ? '0 : sel == 1 ? N'(1) << ($urandom % N) : N'($urandom);
         step(1'($urandom % 2), d, 1'($urandom % 4 != 0), 1'($urandom % 60 == 0));
      end
      for (int i = 0; i < 100 && q.size() > 0; i++) step(0, '0, 1, 0);
      repeat (3) step(0, '0, 1, 0);
      chk("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prio_enc_scan.md
PRIO_ENC_SCAN -- requirements
Module: prio_enc_scan

Interface
REQ-001 Parameter N, default 8, SHALL set the request vector width, legal for N >= 2.
REQ-002 Local parameter W = $clog2(N) SHALL set the index width.
REQ-003 Clocking SHALL be one clock with a synchronous, active-high reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL mark in_data as offered.
REQ-007 in_ready  output  1  SHALL signal that the block can accept in_data.
REQ-008 in_data  input  N  SHALL carry the request vector; bit 0 has highest priority.
REQ-009 out_valid  output  1  SHALL mark out_idx as valid.
REQ-010 out_ready  input  1  SHALL mark that the consumer accepts out_idx.
REQ-011 out_idx  output  W  SHALL carry the index of the current set bit.
REQ-012 out_last  output  1  SHALL mark the final index of the captured vector.
REQ-013 zero_in  output  1  SHALL pulse for one cycle when an all-zero vector is accepted.

Function
REQ-014 FSM states SHALL be IDLE and SCAN; a pending register of N bits SHALL hold unreported bits.
REQ-015 in_ready SHALL equal (state == IDLE), driven combinationally from state only.
REQ-016 Accept SHALL be in_valid && in_ready; in_data while in_ready = 0 SHALL be ignored and need not be held.
REQ-017 On accept of a nonzero vector: pending <= in_data, state -> SCAN, out_valid = 1 from the next cycle (1-cycle latency).
REQ-018 On accept of an all-zero vector: state stays IDLE, no out_valid, zero_in = 1 for exactly the next cycle.
REQ-019 In SCAN: out_idx SHALL be the lowest set bit index of pending, and out_last = 1 iff pending has exactly one bit set.
REQ-020 On out_valid && out_ready: clear that bit in pending; if out_last, state -> IDLE and out_valid = 0 next cycle.
REQ-021 While out_valid && !out_ready: out_idx, out_last and pending SHALL hold stable.
REQ-022 Throughput SHALL be one index per cycle with out_ready held high; a k-bit vector takes k SCAN cycles.
REQ-023 A new vector SHALL be accepted no earlier than the cycle after the last beat; there is no overlap.

Reset
REQ-024 On rst: state = IDLE, pending = 0, out_valid = 0, out_idx = 0, out_last = 0, zero_in = 0.
REQ-025 On the first cycle after reset, in_ready SHALL be 1.
REQ-026 rst mid-SCAN SHALL abort the scan; remaining bits are discarded and never reported.
REQ-027 rst SHALL take priority over a simultaneous accept or handshake.

Configuration
REQ-028 With macro PRIO_ENC_SCAN_CNT_EN defined: add output out_cnt, width W+1, equal to popcount(pending) including the current bit, valid with out_valid and 0 otherwise.
REQ-029 Without PRIO_ENC_SCAN_CNT_EN: the out_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 Package prio_enc_pkg SHALL hold: the state enum typedef (IDLE, SCAN), the lowest-set-bit function and the popcount function.
REQ-031 A combinational sub-module prio_enc_lsb (parameter N; outputs idx[W-1:0], any, onehot) SHALL compute out_idx, out_last and nonzero detection.
REQ-032 All outputs except in_ready SHALL be registered or derived from registered state only.

Verification (N = 8 unless stated)
REQ-033 Single bit: accept 8'b0000_0001 with out_ready = 1 -> one beat with out_idx = 0 and out_last = 1; in_ready = 1 on the following cycle.
REQ-034 Multi-bit: accept 8'b1000_0100 with out_ready = 1 -> out_idx 2 then 7, out_last only on 7; exactly 2 out_valid cycles.
REQ-035 Zero input: accept 8'h00 -> out_valid stays 0 and zero_in = 1 for exactly one cycle.
REQ-036 Backpressure: accept 8'b0010_0010 with out_ready low for 3 cycles -> out_idx = 1 held stable; then 1 and 5 are delivered; in_valid offered during SCAN is not accepted.
REQ-037 Reset mid-scan: accept 8'hFF, consume 2 beats, assert rst -> next cycle out_valid = 0, in_ready = 1, and no index 2..7 is ever reported.
REQ-038 N = 4 with PRIO_ENC_SCAN_CNT_EN: accept 4'b1111 -> out_idx 0,1,2,3 paired with out_cnt 4,3,2,1; out_last only on idx 3.
